// File: rtl/onehot_ring_pkg.sv
// Shared types and helpers for the one-hot ring counter and its bench.
package onehot_ring_pkg;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  // Callers zero-extend their vector to this width before calling is_onehot().
  localparam int ONEHOT_MAXW = 64;

  function automatic logic is_onehot(input logic [ONEHOT_MAXW-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < ONEHOT_MAXW; i++) n += 32'(v[i]);
    return (n == 1);
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// One-hot to binary encoder (OR-reduction form). All-zero input encodes to 0.
module onehot_encoder
  import onehot_ring_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot_i,
  output logic [IDXW-1:0]  index_o
);

  always_comb begin
    index_o = '0;
    for (int i = 0; i < WIDTH; i++)
      if (onehot_i[i]) index_o = index_o | IDXW'(i);
  end

endmodule

// File: rtl/onehot_ring.sv
// Parametrised one-hot ring counter with enable, direction, index load and wrap pulse.
// Optional self-repair checker and err output when ONEHOT_RING_SAFE_EN is defined.
module onehot_ring
  import onehot_ring_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_IDX = 0,
  localparam int IDXW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [IDXW-1:0]  load_idx,
  output logic [WIDTH-1:0] count,
  output logic [IDXW-1:0]  index,
`ifdef ONEHOT_RING_SAFE_EN
  output logic             err,
`endif
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(1) << RESET_IDX;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             fix;

`ifdef ONEHOT_RING_SAFE_EN
  logic err_q;
  assign fix = ~is_onehot(ONEHOT_MAXW'(count_q));
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= fix;
  end
`else
  assign fix = 1'b0;
`endif

  // Out-of-range load_idx matches no bit and so leaves the all-zero illegal state.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (fix) begin
      count_d = RST_VEC;
    end else if (load) begin
      count_d = '0;
      for (int i = 0; i < WIDTH; i++)
        if (load_idx == IDXW'(i)) count_d[i] = 1'b1;
    end else if (en) begin
      if (dir_e'(dir) == DIR_UP) begin
        count_d = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
        wrap_d  = count_q[WIDTH-1];
      end else begin
        count_d = {count_q[0], count_q[WIDTH-1:1]};
        wrap_d  = count_q[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_VEC;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

  onehot_encoder #(.WIDTH(WIDTH)) u_enc (
    .onehot_i (count_q),
    .index_o  (index)
  );

endmodule

// File: tb/tb_onehot_ring.sv
// Scoreboard bench for onehot_ring: driver pushes expectations, negedge monitor checks.
module tb_onehot_ring;
  import onehot_ring_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [2:0] load_idx = '0;
  logic       en6 = 1'b0, load6 = 1'b0;
  logic [2:0] li6 = '0;

  logic [7:0] cA, cB;
  logic [5:0] cC;
  logic [2:0] iA, iB, iC;
  logic       wA, wB, wC;
`ifdef ONEHOT_RING_SAFE_EN
  logic       eA, eB, eC;
`endif

  onehot_ring #(.WIDTH(8), .RESET_IDX(0)) u_a (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_idx(load_idx),
    .count(cA), .index(iA),
`ifdef ONEHOT_RING_SAFE_EN
    .err(eA),
`endif
    .wrap(wA));

  onehot_ring #(.WIDTH(8), .RESET_IDX(3)) u_b (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_idx(load_idx),
    .count(cB), .index(iB),
`ifdef ONEHOT_RING_SAFE_EN
    .err(eB),
`endif
    .wrap(wB));

  onehot_ring #(.WIDTH(6), .RESET_IDX(0)) u_c (
    .clk(clk), .reset(reset), .en(en6), .dir(dir), .load(load6), .load_idx(li6),
    .count(cC), .index(iC),
`ifdef ONEHOT_RING_SAFE_EN
    .err(eC),
`endif
    .wrap(wC));

  typedef struct {
    int         inst;
    logic [7:0] c;
    logic [2:0] i;
    logic       w;
    logic       e;
    logic       oh;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [2:0] enc(input logic [7:0] v);
    for (int k = 0; k < 8; k++) if (v[k]) return 3'(k);
    return 3'd0;
  endfunction

  // Drive one cycle's inputs just after the negedge; result is visible at the following negedge.
  task automatic cyc(input int inst, input logic r, input logic e, input logic d, input logic l,
                     input logic [2:0] li, input logic [7:0] xc, input logic xw, input logic xe,
                     input logic oh, input string nm);
    exp_t x;
    @(negedge clk); #1;
    reset = r; dir = d;
    if (inst == 2) begin
      en = 1'b0; load = 1'b0; en6 = e; load6 = l; li6 = li;
    end else begin
      en = e; load = l; load_idx = li; en6 = 1'b0; load6 = 1'b0;
    end
    x.inst = inst; x.c = xc; x.i = enc(xc); x.w = xw; x.e = xe; x.oh = oh; x.nm = nm;
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t x;
      logic [7:0] ac;
      logic [2:0] ai;
      logic aw, ae;
      x = sbq.pop_front();
      ae = 1'b0;
      case (x.inst)
        0: begin ac = cA; ai = iA; aw = wA;
`ifdef ONEHOT_RING_SAFE_EN
          ae = eA;
`endif
        end
        1: begin ac = cB; ai = iB; aw = wB;
`ifdef ONEHOT_RING_SAFE_EN
          ae = eB;
`endif
        end
        default: begin ac = {2'b00, cC}; ai = iC; aw = wC;
`ifdef ONEHOT_RING_SAFE_EN
          ae = eC;
`endif
        end
      endcase
      n_vec++;
      if (ac !== x.c) begin n_miss++; $display("FAIL %s count got %b want %b", x.nm, ac, x.c); end
      n_vec++;
      if (ai !== x.i) begin n_miss++; $display("FAIL %s index got %0d want %0d", x.nm, ai, x.i); end
      n_vec++;
      if (aw !== x.w) begin n_miss++; $display("FAIL %s wrap got %b want %b", x.nm, aw, x.w); end
`ifdef ONEHOT_RING_SAFE_EN
      n_vec++;
      if (ae !== x.e) begin n_miss++; $display("FAIL %s err got %b want %b", x.nm, ae, x.e); end
`endif
      if (x.oh) begin
        n_vec++;
        if (is_onehot(ONEHOT_MAXW'(ac)) !== 1'b1) begin
          n_miss++; $display("FAIL %s onehot got %b want one bit set", x.nm, ac);
        end
      end
    end
  end

  logic [7:0] up_tbl [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

  initial begin
    logic [7:0] mc, nc;
    logic       mw, r, l, e, d;
    logic [2:0] li;

    // Reset held over several edges, both reset positions.
    cyc(0, 1, 0, 0, 0, 3'd0, 8'h01, 0, 0, 0, "rst_a0");
    cyc(0, 1, 1, 0, 0, 3'd0, 8'h01, 0, 0, 0, "rst_a1");
    cyc(1, 1, 1, 0, 0, 3'd0, 8'h08, 0, 0, 0, "rst_b");

    // Step toward MSB around the full ring.
    for (int k = 0; k < 8; k++)
      cyc(0, 0, 1, 0, 0, 3'd0, up_tbl[k], (k == 7), 0, 0, "up");

    // Step toward LSB across the boundary, then hold.
    cyc(0, 0, 1, 1, 0, 3'd0, 8'h80, 1, 0, 0, "dn_wrap");
    cyc(0, 0, 1, 1, 0, 3'd0, 8'h40, 0, 0, 0, "dn");
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 0, k[0], 0, 3'd0, 8'h40, 0, 0, 0, "hold");

    // Load priority over en; reset priority over load.
    cyc(0, 0, 1, 0, 1, 3'd5, 8'h20, 0, 0, 0, "load5");
    cyc(0, 0, 1, 1, 0, 3'd0, 8'h10, 0, 0, 0, "dn_after_load");
    cyc(0, 0, 1, 0, 1, 3'd7, 8'h80, 0, 0, 0, "load7");
    cyc(0, 0, 1, 0, 0, 3'd0, 8'h01, 1, 0, 0, "up_wrap2");
    cyc(0, 1, 1, 0, 1, 3'd6, 8'h01, 0, 0, 0, "rst_over_load");

    // WIDTH=6: out-of-range load gives the illegal all-zero state.
    cyc(2, 0, 0, 0, 1, 3'd7, 8'h00, 0, 0, 0, "w6_ill");
`ifdef ONEHOT_RING_SAFE_EN
    cyc(2, 0, 1, 0, 0, 3'd0, 8'h01, 0, 1, 0, "w6_fix");
    cyc(2, 0, 1, 0, 0, 3'd0, 8'h02, 0, 0, 0, "w6_run");
    cyc(2, 0, 1, 0, 0, 3'd0, 8'h04, 0, 0, 0, "w6_run");
    cyc(2, 0, 1, 0, 0, 3'd0, 8'h08, 0, 0, 0, "w6_run");
`else
    for (int k = 0; k < 4; k++)
      cyc(2, 0, 1, k[0], 0, 3'd0, 8'h00, 0, 0, 0, "w6_stuck");
`endif
    cyc(2, 0, 1, 0, 1, 3'd5, 8'h20, 0, 0, 0, "w6_load5");
    cyc(2, 0, 1, 0, 0, 3'd0, 8'h01, 1, 0, 0, "w6_up_wrap");
    cyc(2, 0, 1, 1, 0, 3'd0, 8'h20, 1, 0, 0, "w6_dn_wrap");
    cyc(2, 0, 0, 0, 1, 3'd6, 8'h00, 0, 0, 0, "w6_ill6");
`ifdef ONEHOT_RING_SAFE_EN
    cyc(2, 0, 0, 0, 1, 3'd2, 8'h01, 0, 1, 0, "w6_fix_over_load");
`else
    cyc(2, 0, 0, 0, 1, 3'd2, 8'h04, 0, 0, 0, "w6_recover");
`endif

    // Random run against the reference model.
    cyc(0, 1, 0, 0, 0, 3'd0, 8'h01, 0, 0, 0, "rand_rst");
    mc = 8'h01;
    for (int n = 0; n < 1000; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = 1'($urandom_range(0, 1));
      d  = 1'($urandom_range(0, 1));
      li = 3'($urandom_range(0, 7));
      mw = 1'b0;
      nc = mc;
      if (r)      nc = 8'h01;
      else if (l) nc = 8'h01 << li;
      else if (e) begin
        if (!d) begin mw = mc[7]; nc = {mc[6:0], mc[7]}; end
        else    begin mw = mc[0]; nc = {mc[0], mc[7:1]}; end
      end
      mc = nc;
      cyc(0, r, e, d, l, li, mc, mw, 0, 1, "rand");
    end

    @(negedge clk); #1;
    en = 1'b0; load = 1'b0;
    for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_miss++;
      $display("FAIL drain pending got %0d want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
